// File: rtl/mips_encode.sv
// MIPS ALU request encoder with a 4-deep output queue.
// Illegal requests are consumed, counted and flagged but never queued.
module mips_encode (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  alu_op,
  input  logic [1:0]  alu_src2,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        except,
  output logic [15:0] inst_count,
  output logic [7:0]  err_count
);

  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOR = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  logic [31:0] r_mem [4];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;
  logic        r_except;
  logic [15:0] r_inst_count;
  logic [7:0]  r_err_count;

  logic        w_legal;
  logic [5:0]  w_funct;
  logic [5:0]  w_opc;
  logic [31:0] w_inst;
  logic        w_acc;
  logic        w_push;
  logic        w_illegal;
  logic        w_pop;

  always_comb begin
    w_legal = 1'b0;
    w_funct = 6'h00;
    w_opc   = 6'h00;
    unique case (alu_op)
      OP_ADD:  w_funct = 6'h20;
      OP_SUB:  w_funct = 6'h22;
      OP_AND:  w_funct = 6'h24;
      OP_OR:   w_funct = 6'h25;
      OP_NOR:  w_funct = 6'h27;
      OP_XOR:  w_funct = 6'h26;
      default: w_funct = 6'h00;
    endcase
    unique case (alu_src2)
      2'd0: w_legal = (alu_op >= OP_ADD);
      2'd1: begin
        w_legal = (alu_op == OP_ADD);
        w_opc   = 6'h08;
      end
      2'd2: begin
        unique case (alu_op)
          OP_AND:  begin w_legal = 1'b1; w_opc = 6'h0c; end
          OP_OR:   begin w_legal = 1'b1; w_opc = 6'h0d; end
          OP_XOR:  begin w_legal = 1'b1; w_opc = 6'h0e; end
          default: w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
    if (alu_src2 == 2'd0)
      w_inst = {6'h00, rs, rt, rd, 5'b0, w_funct};
    else
      w_inst = {w_opc, rs, rd, imm};
  end

  assign in_ready   = (r_count < 3'd4);
  assign out_valid  = (r_count != 3'd0);
  assign out_inst   = r_mem[r_rptr];
  assign except     = r_except;
  assign inst_count = r_inst_count;
  assign err_count  = r_err_count;

  assign w_acc     = in_valid && in_ready;
  assign w_push    = w_acc && w_legal;
  assign w_illegal = w_acc && !w_legal;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr       <= 2'd0;
      r_rptr       <= 2'd0;
      r_count      <= 3'd0;
      r_except     <= 1'b0;
      r_inst_count <= 16'd0;
      r_err_count  <= 8'd0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + 2'd1;
      if (w_pop) begin
        r_rptr       <= r_rptr + 2'd1;
        r_inst_count <= r_inst_count + 16'd1;
      end
      r_count  <= r_count + {2'b0, w_push} - {2'b0, w_pop};
      r_except <= w_illegal;
      if (w_illegal && (r_err_count != 8'hFF))
        r_err_count <= r_err_count + 8'd1;
    end
  end

  // Storage holds no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clock) begin
    if (w_push)
      r_mem[r_wptr] <= w_inst;
  end

endmodule

// File: tb/tb_mips_encode.sv
// Scoreboard bench for mips_encode: driver queues expected words,
// monitor pops and compares on each output handshake.
module tb_mips_encode;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [1:0]  alu_src2;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        except;
  logic [15:0] inst_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  logic        pend_exc = 1'b0;
  logic        exc_exp  = 1'b0;
  logic [15:0] exp_inst = 16'd0;
  logic [7:0]  exp_err  = 8'd0;
  logic        acc;

  always #5 clock = ~clock;

  mips_encode dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_src2(alu_src2),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .except(except),
    .inst_count(inst_count), .err_count(err_count)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // One cycle: inputs set at posedge+1, acceptance seen at negedge.
  task automatic step(input logic v, input logic [2:0] op,
                      input logic [1:0] s2, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d,
                      input logic [15:0] im, input logic [31:0] ex,
                      input logic lg, input logic ordy,
                      output logic ac);
    in_valid = v; alu_op = op; alu_src2 = s2;
    rs = a; rt = b; rd = d; imm = im; out_ready = ordy;
    @(negedge clock);
    ac = v && in_ready;
    if (ac && lg) sb.push_back(ex);
    if (ac && !lg) begin
      pend_exc = 1'b1;
      if (exp_err != 8'hFF) exp_err++;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic a;
    for (int i = 0; i < n; i++)
      step(1'b0, 3'd0, 2'd3, 5'd7, 5'd7, 5'd7, 16'h1111,
           32'h0, 1'b0, ordy, a);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
    pend_exc = 1'b0; exc_exp = 1'b0;
    exp_inst = 16'd0; exp_err = 8'd0;
  endtask

  initial begin
    forever begin
      @(negedge clock); #1;
      if (!reset) begin
        chk("except", {31'd0, except}, {31'd0, exc_exp});
        exc_exp  = pend_exc;
        pend_exc = 1'b0;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word got=%h expected=none", out_inst);
          end else begin
            chk("out_inst", out_inst, sb.pop_front());
          end
          exp_inst++;
        end
      end
    end
  end

  initial begin
    in_valid = 0; alu_op = 0; alu_src2 = 0;
    rs = 0; rt = 0; rd = 0; imm = 0; out_ready = 0;
    do_reset(2);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_inst_count", {16'd0, inst_count}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_except", {31'd0, except}, 32'd0);

    // Single ADD R-type: one-cycle latency then inst_count=1
    step(1, 3'd2, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221820, 1, 1, acc);
    chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_out_inst", out_inst, 32'h00221820);
    idle(1, 1);
    chk("add_inst_count", {16'd0, inst_count}, 32'd1);

    step(1, 3'd3, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221822, 1, 1, acc);
    step(1, 3'd4, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221824, 1, 1, acc);
    step(1, 3'd5, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221825, 1, 1, acc);
    step(1, 3'd7, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221826, 1, 1, acc);
    step(1, 3'd6, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221827, 1, 1, acc);
    step(1, 3'd2, 2'd1, 5'd1, 5'd0, 5'd2, 16'h0005, 32'h20220005, 1, 1, acc);
    step(1, 3'd2, 2'd1, 5'd1, 5'd31, 5'd2, 16'h8000, 32'h20228000, 1, 1, acc);
    step(1, 3'd5, 2'd2, 5'd4, 5'd0, 5'd5, 16'hFFFF, 32'h3485FFFF, 1, 1, acc);
    step(1, 3'd4, 2'd2, 5'd4, 5'd9, 5'd5, 16'h1234, 32'h30851234, 1, 1, acc);
    step(1, 3'd7, 2'd2, 5'd4, 5'd0, 5'd5, 16'hABCD, 32'h3885ABCD, 1, 1, acc);
    idle(2, 1);
    chk("seq_inst_count", {16'd0, inst_count}, 32'd11);
    chk("seq_sb_empty", sb.size(), 32'd0);

    // Fill with out_ready=0: fifth request must be refused
    step(1, 3'd2, 2'd0, 5'd1, 5'd2, 5'd1, 16'h0, 32'h00220820, 1, 0, acc);
    step(1, 3'd2, 2'd0, 5'd1, 5'd2, 5'd2, 16'h0, 32'h00221020, 1, 0, acc);
    step(1, 3'd2, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221820, 1, 0, acc);
    chk("fill_in_ready3", {31'd0, in_ready}, 32'd1);
    step(1, 3'd2, 2'd0, 5'd1, 5'd2, 5'd4, 16'h0, 32'h00222020, 1, 0, acc);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    step(1, 3'd2, 2'd0, 5'd1, 5'd2, 5'd5, 16'h0, 32'h00222820, 1, 1, acc);
    chk("full_reject", {31'd0, acc}, 32'd0);
    idle(5, 1);
    chk("drain_inst_count", {16'd0, inst_count}, 32'd15);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // Illegal requests: pulse, count, nothing queued
    step(1, 3'd3, 2'd1, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0, 1, acc);
    chk("ill_except", {31'd0, except}, 32'd1);
    chk("ill_err_count", {24'd0, err_count}, 32'd1);
    chk("ill_out_valid", {31'd0, out_valid}, 32'd0);
    idle(1, 1);
    chk("ill_except_clr", {31'd0, except}, 32'd0);
    step(1, 3'd0, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0, 1, acc);
    step(1, 3'd1, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0, 1, acc);
    step(1, 3'd5, 2'd3, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0, 1, acc);
    step(1, 3'd2, 2'd2, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0, 1, acc);
    step(1, 3'd6, 2'd2, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0, 1, acc);
    idle(2, 1);
    chk("ill_err_count6", {24'd0, err_count}, 32'd6);
    chk("ill_no_words", {16'd0, inst_count}, 32'd15);

    // count=2 with push and pop together, then refill to prove count
    step(1, 3'd2, 2'd0, 5'd10, 5'd11, 5'd12, 16'h0, 32'h014B6020, 1, 0, acc);
    step(1, 3'd3, 2'd0, 5'd10, 5'd11, 5'd12, 16'h0, 32'h014B6022, 1, 0, acc);
    step(1, 3'd4, 2'd0, 5'd10, 5'd11, 5'd12, 16'h0, 32'h014B6024, 1, 1, acc);
    step(1, 3'd5, 2'd0, 5'd10, 5'd11, 5'd12, 16'h0, 32'h014B6025, 1, 0, acc);
    step(1, 3'd7, 2'd0, 5'd10, 5'd11, 5'd12, 16'h0, 32'h014B6026, 1, 0, acc);
    chk("pp_full", {31'd0, in_ready}, 32'd0);
    // Illegal request while popping
    out_ready = 1'b1;
    step(1, 3'd1, 2'd1, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 0, 1, acc);
    chk("full_ill_reject", {31'd0, acc}, 32'd0);
    step(1, 3'd1, 2'd1, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 0, 1, acc);
    chk("pop_ill_except", {31'd0, except}, 32'd1);
    idle(5, 1);
    chk("pp_inst_count", {16'd0, inst_count}, 32'd20);
    chk("pp_err_count", {24'd0, err_count}, 32'd7);

    // Reset with three words queued
    step(1, 3'd2, 2'd0, 5'd1, 5'd1, 5'd1, 16'h0, 32'h00210820, 1, 0, acc);
    step(1, 3'd2, 2'd0, 5'd2, 5'd2, 5'd2, 16'h0, 32'h00421020, 1, 0, acc);
    step(1, 3'd2, 2'd0, 5'd3, 5'd3, 5'd3, 16'h0, 32'h00631820, 1, 0, acc);
    do_reset(1);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_inst_count", {16'd0, inst_count}, 32'd0);
    chk("mid_err_count", {24'd0, err_count}, 32'd0);
    idle(3, 1);
    chk("mid_no_stale", {16'd0, inst_count}, 32'd0);

    // err_count saturation
    for (int i = 0; i < 260; i++)
      step(1, 3'd0, 2'd1, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0, 0, 1, acc);
    idle(1, 1);
    chk("err_saturate", {24'd0, err_count}, 32'd255);
    chk("err_model", {24'd0, err_count}, {24'd0, exp_err});

    // inst_count wrap
    do_reset(1);
    for (int i = 0; i < 65535; i++)
      step(1, 3'd2, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221820, 1, 1, acc);
    idle(2, 1);
    chk("inst_ffff", {16'd0, inst_count}, 32'h0000FFFF);
    step(1, 3'd3, 2'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221822, 1, 1, acc);
    idle(2, 1);
    chk("inst_wrap", {16'd0, inst_count}, 32'd0);
    chk("inst_model", {16'd0, inst_count}, {16'd0, exp_inst});
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
